// File: rtl/axi4lite_regbank_pix28_if.sv
// AXI4-Lite bus bundle for the pix28 register bank.
// The slave modport faces the register bank; the master modport faces the interconnect.
interface axi4lite_regbank_pix28_if #(
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_ADDR_WIDTH = 11
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi4lite_regbank_pix28.sv
// AXI4-Lite slave with N control registers and M status registers for the pix28 firmware.
// Independent write and read FSMs; write/read event pulses, self-clearing bits in register 0.
module axi4lite_regbank_pix28 #(
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_ADDR_WIDTH = 11,
    parameter int N_WR_REGS          = 4,
    parameter int N_RD_REGS          = 4,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] PULSE_MASK = '0
) (
    input  logic                                      S_AXI_ACLK,
    input  logic                                      S_AXI_ARESETN,
    axi4lite_regbank_pix28_if.slave                   s_axi,
    output logic [N_WR_REGS*C_S_AXI_DATA_WIDTH-1:0]   sw_write_regs,
    input  logic [N_RD_REGS*C_S_AXI_DATA_WIDTH-1:0]   sw_read_regs,
    output logic [N_WR_REGS-1:0]                      sw_wr_pulse,
    output logic [N_RD_REGS-1:0]                      sw_rd_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int NBYTES   = DW / 8;
    localparam int ADDR_LSB = $clog2(NBYTES);
    localparam int IDX_W    = AW - ADDR_LSB;

    localparam logic [IDX_W-1:0] NWR_IDX = IDX_W'(N_WR_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (C_S_AXI_DATA_WIDTH != 32 && C_S_AXI_DATA_WIDTH != 64) begin : g_bad_dw
        $error("axi4lite_regbank_pix28: C_S_AXI_DATA_WIDTH must be 32 or 64");
    end

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_RESP} rstate_t;

    wstate_t                        wstate_q;
    logic                           awready_q;
    logic                           wready_q;
    logic                           bvalid_q;
    logic [1:0]                     bresp_q;
    logic [N_WR_REGS-1:0][DW-1:0]   ctrl_q;
    logic [N_WR_REGS-1:0][DW-1:0]   ctrl_d;
    logic [N_WR_REGS-1:0]           wr_pulse_q;
    logic [N_WR_REGS-1:0]           wr_pulse_d;

    rstate_t                        rstate_q;
    logic                           arready_q;
    logic                           rvalid_q;
    logic [1:0]                     rresp_q;
    logic [1:0]                     rresp_d;
    logic [DW-1:0]                  rdata_q;
    logic [DW-1:0]                  rdata_d;
    logic [N_RD_REGS-1:0]           rd_pulse_q;
    logic [N_RD_REGS-1:0]           rd_hit_d;

    logic [IDX_W-1:0]               widx;
    logic [IDX_W-1:0]               ridx;
    logic                           w_legal;

    // The master holds AW/W stable while READY is high, so the bus values are
    // taken directly on the edge that leaves W_ACCEPT.
    assign widx    = s_axi.S_AXI_AWADDR[AW-1:ADDR_LSB];
    assign ridx    = s_axi.S_AXI_ARADDR[AW-1:ADDR_LSB];
    assign w_legal = (widx < NWR_IDX);

    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Register 0 drops its self-clearing bits every cycle unless rewritten.
    always_comb begin
        ctrl_d     = ctrl_q;
        ctrl_d[0]  = ctrl_q[0] & ~PULSE_MASK;
        wr_pulse_d = '0;
        if (wstate_q == W_ACCEPT) begin
            for (int k = 0; k < N_WR_REGS; k++) begin
                if (widx == IDX_W'(k)) begin
                    wr_pulse_d[k] = 1'b1;
                    for (int b = 0; b < NBYTES; b++) begin
                        if (s_axi.S_AXI_WSTRB[b]) begin
                            ctrl_d[k][8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_q   <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            ctrl_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            wr_pulse_q <= wr_pulse_d;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            case (wstate_q)
                W_IDLE: begin
                    if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                        wstate_q  <= W_ACCEPT;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_ACCEPT: begin
                    wstate_q <= W_RESP;
                    bvalid_q <= 1'b1;
                    bresp_q  <= w_legal ? RESP_OKAY : RESP_SLVERR;
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        wstate_q <= W_IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                default: begin
                    wstate_q <= W_IDLE;
                    bvalid_q <= 1'b0;
                end
            endcase
        end
    end

    // Read mux: unmatched indices fall through to zero data with SLVERR.
    always_comb begin
        rdata_d  = '0;
        rresp_d  = RESP_SLVERR;
        rd_hit_d = '0;
        for (int k = 0; k < N_WR_REGS; k++) begin
            if (ridx == IDX_W'(k)) begin
                rdata_d = (k == 0) ? (ctrl_q[k] & ~PULSE_MASK) : ctrl_q[k];
                rresp_d = RESP_OKAY;
            end
        end
        for (int j = 0; j < N_RD_REGS; j++) begin
            if (ridx == IDX_W'(N_WR_REGS + j)) begin
                rdata_d     = sw_read_regs[j*DW +: DW];
                rresp_d     = RESP_OKAY;
                rd_hit_d[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rstate_q   <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rd_pulse_q <= '0;
        end else begin
            rd_pulse_q <= '0;
            arready_q  <= 1'b0;
            case (rstate_q)
                R_IDLE: begin
                    if (s_axi.S_AXI_ARVALID) begin
                        rstate_q  <= R_ACCEPT;
                        arready_q <= 1'b1;
                    end
                end
                R_ACCEPT: begin
                    rstate_q   <= R_RESP;
                    rvalid_q   <= 1'b1;
                    rdata_q    <= rdata_d;
                    rresp_q    <= rresp_d;
                    rd_pulse_q <= rd_hit_d;
                end
                R_RESP: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rstate_q <= R_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    rstate_q <= R_IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;

    assign sw_write_regs = ctrl_q;
    assign sw_wr_pulse   = wr_pulse_q;
    assign sw_rd_pulse   = rd_pulse_q;

endmodule
